pipeline_sched: RTL and testbench
=================================

Name: pipeline_sched

Overview:
- Central sequencing controller for the 5-stage MIPS pipeline.
- Drives the enable and flush of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use stalls and taken-branch/jump flushes.
- Implements debug-unit run/step/pause control and drains the pipeline when a HALT instruction is decoded.

Parameters:
- NBITS, 32, width of the cycle counter output.
- DRAIN_CYC, 3, cycles the back stages keep advancing after HALT is decoded (EX, MEM, WB).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_run  in  1  debug pulse: start continuous execution.
- i_step  in  1  debug pulse: advance the pipeline exactly one clock.
- i_pause  in  1  debug pulse: stop continuous execution.
- i_id_rs  in  5  rs field of the instruction in IF/ID.
- i_id_rt  in  5  rt field of the instruction in IF/ID.
- i_id_halt  in  1  IF/ID instruction decodes as HALT.
- i_ex_mem_read  in  1  ID/EX holds a load (mem_op=1, mem_type=read).
- i_ex_rt  in  5  destination rt of the load in ID/EX.
- i_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- o_pc_en  out  1  PC load enable.
- o_if_id_en  out  1  IF/ID load enable.
- o_if_id_flush  out  1  IF/ID synchronous clear to NOP.
- o_id_ex_en  out  1  ID/EX load enable.
- o_id_ex_flush  out  1  ID/EX synchronous clear to bubble.
- o_ex_mem_en  out  1  EX/MEM load enable.
- o_mem_wb_en  out  1  MEM/WB load enable.
- o_running  out  1  state is RUN.
- o_halted  out  1  state is HALTED.
- o_cycles  out  NBITS  count of active cycles.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE, drain counter=0, o_cycles=0. All enables, flushes, o_running and o_halted are 0.
- States and transitions:
  - IDLE: i_run → RUN; otherwise i_step → STEP. i_run and i_step together → RUN.
  - RUN: i_pause → IDLE after the current cycle (the current cycle still advances). i_step is ignored.
  - STEP: lasts exactly one cycle, then returns to IDLE.
  - DRAIN: runs autonomously; i_run, i_step and i_pause are ignored.
  - HALTED: terminal; only reset exits.
- Active cycle: the cycle is active when state ∈ {RUN, STEP}. Default outputs in an active cycle: all *_en=1, flushes=0.
- Hazard priority within an active cycle (highest first):
  1. Branch taken (i_branch_taken=1): o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1 (PC loads the target). Any HALT or load-use seen in ID this cycle is discarded with the flushed instruction.
  2. HALT (i_id_halt=1): o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; EX/MEM and MEM/WB enabled. Next state DRAIN, drain counter loaded with DRAIN_CYC-1.
  3. Load-use (i_ex_mem_read=1, i_ex_rt≠0, and i_ex_rt equals i_id_rs or i_id_rt): o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; back stages enabled. The stall lasts one cycle because the load has moved past ID/EX on the next cycle.
- DRAIN: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_ex_mem_en=1, o_mem_wb_en=1. The drain counter decrements each cycle; at 0 the next state is HALTED. DRAIN therefore lasts exactly DRAIN_CYC cycles.
- IDLE and HALTED: all enables 0, flushes 0, pipeline frozen.
- Output timing: enables and flushes are combinational from state and hazard inputs, valid in the same cycle. o_running and o_halted decode the state register only.
- o_cycles: increments by 1 on each RUN, STEP or DRAIN cycle. Saturates at 2^NBITS−1 (no wrap).
- Reset mid-operation (any state): immediate return to IDLE with all outputs 0; no partial drain.

Decomposition:
- Shared pipeline package holds:
  - the state encoding (IDLE, RUN, STEP, DRAIN, HALTED), 3 bits;
  - the HALT opcode constant;
  - the register-zero index constant.
- One sub-module, hazard_detect: purely combinational; computes the load-use match and the priority-resolved enable/flush vector for an active cycle. The FSM, drain counter and cycle counter remain in pipeline_sched.

Test Plan:
1. Reset, then i_run pulse → o_running=1 on the next cycle, all enables 1, o_cycles = 1, 2, 3… Assert i_rst=0 mid-run → all outputs 0 immediately.
2. RUN, i_ex_mem_read=1, i_ex_rt=5, i_id_rs=5 → exactly one cycle of o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1. Repeat with i_ex_rt=0 → no stall.
3. RUN, i_branch_taken=1 together with i_id_halt=1 → o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1, state stays RUN.
4. RUN, i_id_halt=1 → DRAIN for exactly 3 cycles (o_ex_mem_en=1, o_pc_en=0), then o_halted=1. A subsequent i_run has no effect.
5. IDLE, three i_step pulses spaced apart → exactly 3 single-cycle enable windows, o_cycles=3. i_run and i_step together → RUN.
6. NBITS=4, RUN for 20 cycles → o_cycles saturates at 15. i_pause → IDLE, enables 0, o_cycles holds at 15.

Source files
------------

// File: rtl/pipeline_sched_pkg.sv
// Shared definitions for the 5-stage pipeline sequencer: state encoding,
// pipeline control vector and decode helpers.
package pipeline_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam logic [4:0] REG_ZERO    = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctrl_t;

  // Field order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en
  localparam pipe_ctrl_t CTRL_FROZEN  = 7'b000_0000;
  localparam pipe_ctrl_t CTRL_ADVANCE = 7'b110_1011;
  localparam pipe_ctrl_t CTRL_BRANCH  = 7'b111_1111;
  localparam pipe_ctrl_t CTRL_STALL   = 7'b000_1111;

  function automatic logic is_halt_opcode(input logic [5:0] opcode);
    return (opcode == HALT_OPCODE);
  endfunction

  // Writes to $zero never create a real dependency, so they never stall.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipeline_sched_hazard_detect.sv
// Combinational hazard resolution for one active pipeline cycle:
// branch flush beats HALT, which beats a load-use stall.
module hazard_detect
  import pipeline_sched_pkg::*;
(
  input  logic       id_halt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic       branch_taken_i,
  output pipe_ctrl_t ctrl_o,
  output logic       halt_take_o
);

  logic load_use_s;

  assign load_use_s = load_use_hit(ex_mem_read_i, ex_rt_i, id_rs_i, id_rt_i);

  // Priority-resolved control vector for an active cycle.
  always_comb begin
    ctrl_o      = CTRL_ADVANCE;
    halt_take_o = 1'b0;
    if (branch_taken_i) begin
      ctrl_o = CTRL_BRANCH;
    end else if (id_halt_i) begin
      ctrl_o      = CTRL_STALL;
      halt_take_o = 1'b1;
    end else if (load_use_s) begin
      ctrl_o = CTRL_STALL;
    end else begin
      ctrl_o = CTRL_ADVANCE;
    end
  end

endmodule

// File: rtl/pipeline_sched.sv
// Pipeline sequencing controller: debug run/step/pause FSM, HALT drain,
// hazard-driven enables/flushes and a saturating active-cycle counter.
module pipeline_sched
  import pipeline_sched_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_pause,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_halt,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_branch_taken,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_running,
  output logic             o_halted,
  output logic [NBITS-1:0] o_cycles
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0]   DRAIN_LOAD = DCW'(DRAIN_CYC - 1);
  localparam logic [NBITS-1:0] CYC_MAX    = {NBITS{1'b1}};
  localparam logic [NBITS-1:0] CYC_ONE    = {{(NBITS-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [NBITS-1:0] cycles_q, cycles_d;
  pipe_ctrl_t       hz_ctrl_s, ctrl_s;
  logic             halt_take_s;
  logic             active_s;

  hazard_detect u_hazard_detect (
    .id_halt_i      (i_id_halt),
    .id_rs_i        (i_id_rs),
    .id_rt_i        (i_id_rt),
    .ex_mem_read_i  (i_ex_mem_read),
    .ex_rt_i        (i_ex_rt),
    .branch_taken_i (i_branch_taken),
    .ctrl_o         (hz_ctrl_s),
    .halt_take_o    (halt_take_s)
  );

  assign active_s = (state_q == ST_RUN) || (state_q == ST_STEP);

  // Next-state, drain counter and cycle counter logic.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    cycles_d = cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d = ST_RUN;
        end else if (i_step) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_take_s) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (i_pause) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (halt_take_s) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    if ((active_s || (state_q == ST_DRAIN)) && (cycles_q != CYC_MAX)) begin
      cycles_d = cycles_q + CYC_ONE;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Enables and flushes follow the current state and this cycle's hazards.
  always_comb begin
    ctrl_s = CTRL_FROZEN;
    case (state_q)
      ST_RUN, ST_STEP: ctrl_s = hz_ctrl_s;
      ST_DRAIN:        ctrl_s = CTRL_STALL;
      default:         ctrl_s = CTRL_FROZEN;
    endcase
  end

  // State, drain counter and cycle counter registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      drain_q  <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      cycles_q <= cycles_d;
    end
  end

  assign o_pc_en       = ctrl_s.pc_en;
  assign o_if_id_en    = ctrl_s.if_id_en;
  assign o_if_id_flush = ctrl_s.if_id_flush;
  assign o_id_ex_en    = ctrl_s.id_ex_en;
  assign o_id_ex_flush = ctrl_s.id_ex_flush;
  assign o_ex_mem_en   = ctrl_s.ex_mem_en;
  assign o_mem_wb_en   = ctrl_s.mem_wb_en;
  assign o_running     = (state_q == ST_RUN);
  assign o_halted      = (state_q == ST_HALTED);
  assign o_cycles      = cycles_q;

endmodule

// File: tb/tb_pipeline_sched.sv
// Self-checking bench for pipeline_sched: directed scenarios followed by
// randomized traffic, compared against a behavioural sequencer model.
module tb_pipeline_sched;

  localparam int NB    = 4;
  localparam int DRAIN = 3;
  localparam int CMAX  = (1 << NB) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_run = 1'b0, i_step = 1'b0, i_pause = 1'b0;
  logic [4:0]    i_id_rs = 5'd0, i_id_rt = 5'd0, i_ex_rt = 5'd0;
  logic          i_id_halt = 1'b0, i_ex_mem_read = 1'b0, i_branch_taken = 1'b0;
  logic          o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush;
  logic          o_ex_mem_en, o_mem_wb_en, o_running, o_halted;
  logic [NB-1:0] o_cycles;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: what the sequencer is doing right now.
  bit m_running, m_stepping, m_halted;
  int m_drain_left;
  int m_cycles;

  pipeline_sched #(.NBITS(NB), .DRAIN_CYC(DRAIN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_step(i_step), .i_pause(i_pause),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_halt(i_id_halt),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_branch_taken(i_branch_taken),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_en(o_id_ex_en), .o_id_ex_flush(o_id_ex_flush), .o_ex_mem_en(o_ex_mem_en),
    .o_mem_wb_en(o_mem_wb_en), .o_running(o_running), .o_halted(o_halted),
    .o_cycles(o_cycles)
  );

  always #5 i_clk = ~i_clk;

  function automatic bit m_load_use();
    return i_ex_mem_read && (i_ex_rt != 5'd0) && ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
  endfunction

  // Expected {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  function automatic logic [6:0] m_ctrl();
    bit pc, ifen, iffl, exfl;
    if (m_running || m_stepping) begin
      pc = 1'b1; ifen = 1'b1; iffl = 1'b0; exfl = 1'b0;
      if (i_branch_taken) begin
        iffl = 1'b1; exfl = 1'b1;
      end else if (i_id_halt || m_load_use()) begin
        pc = 1'b0; ifen = 1'b0; exfl = 1'b1;
      end
      return {pc, ifen, iffl, 1'b1, exfl, 1'b1, 1'b1};
    end
    if (m_drain_left > 0) return 7'b000_1111;
    return 7'b000_0000;
  endfunction

  task automatic m_reset();
    m_running = 1'b0; m_stepping = 1'b0; m_halted = 1'b0;
    m_drain_left = 0; m_cycles = 0;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic m_clock();
    bit active;
    active = m_running || m_stepping;
    if (active || m_drain_left > 0) m_cycles = (m_cycles < CMAX) ? m_cycles + 1 : CMAX;
    if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1'b1;
    end else if (active) begin
      if (!i_branch_taken && i_id_halt) begin
        m_running = 1'b0; m_stepping = 1'b0; m_drain_left = DRAIN;
      end else if (m_stepping || i_pause) begin
        m_running = 1'b0; m_stepping = 1'b0;
      end
    end else begin
      if (i_run) m_running = 1'b1;
      else if (i_step) m_stepping = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ctrl", {25'd0, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en,
                   o_id_ex_flush, o_ex_mem_en, o_mem_wb_en}, {25'd0, m_ctrl()});
    check("running", {31'd0, o_running}, {31'd0, m_running});
    check("halted", {31'd0, o_halted}, {31'd0, m_halted});
    check("cycles", {{(32-NB){1'b0}}, o_cycles}, m_cycles);
  endtask

  task automatic drive(input bit run, input bit step, input bit pause,
                       input logic [4:0] rs, input logic [4:0] rt, input bit halt,
                       input bit rd, input logic [4:0] ert, input bit br);
    i_run = run; i_step = step; i_pause = pause; i_id_rs = rs; i_id_rt = rt;
    i_id_halt = halt; i_ex_mem_read = rd; i_ex_rt = ert; i_branch_taken = br;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Check mid-cycle, then cross one rising edge and update the model.
  task automatic tick();
    #1;
    check_all();
    @(posedge i_clk);
    m_clock();
    #2;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    i_rst = 1'b0;
    idle_in();
    #1;
    m_reset();
    check_all();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    do_reset();

    // Continuous run, counter climbs, then reset mid-run.
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    idle_in();
    for (int i = 0; i < 5; i++) tick();
    #3;
    do_reset();

    // Load-use stall for one cycle, then a $zero load that must not stall.
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd5, 5'd7, 1'b0, 1'b0, 5'd5, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd2, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0); tick();

    // Taken branch hides a HALT in ID; run continues.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1); tick();
    idle_in(); tick();

    // HALT drains the back stages, then the controller is terminal.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    idle_in();
    for (int i = 0; i < DRAIN + 1; i++) tick();
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    idle_in(); tick();
    do_reset();

    // Three single steps, then run+step together.
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
      idle_in(); tick(); tick();
    end
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    idle_in(); tick();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    do_reset();

    // Long run saturates the narrow counter; pause freezes everything.
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    idle_in();
    for (int i = 0; i < 20; i++) tick();
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    idle_in(); tick(); tick();

    // Randomized traffic with small register indices to provoke matches.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halted && ($urandom_range(3) == 0)) do_reset();
      drive($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
            5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(19) == 0,
            $urandom_range(1) == 1, 5'($urandom_range(3)), $urandom_range(7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
